// File: rtl/pipe_stim_pkg.sv
// Shared types and constants for the pipe_stim stimulus source.
// The LFSR word mode is built only when PIPE_STIM_LFSR_EN is defined.
package pipe_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Galois feedback taps for the 32-bit LFSR word sequence.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] seed);
        return (seed == 32'd0) ? 32'd1 : seed;
    endfunction

endpackage

// File: rtl/pipe_lfsr32.sv
// Combinational single step of the 32-bit Galois LFSR (shift right, XOR taps on LSB=1).
// Instantiated by pipe_stim_source only when PIPE_STIM_LFSR_EN is defined.
module pipe_lfsr32
    import pipe_stim_pkg::*;
(
    input  logic [31:0] state_in,
    output logic [31:0] state_out
);

    assign state_out = state_in[0] ? ((state_in >> 1) ^ LFSR_TAPS) : (state_in >> 1);

endmodule

// File: rtl/pipe_stim_source.sv
// Burst word generator feeding a downstream pipeline through a valid/ready handshake.
// Define PIPE_STIM_LFSR_EN to add the LFSR word mode selected by i_mode; otherwise count mode only.
module pipe_stim_source
    import pipe_stim_pkg::*;
#(
    parameter logic [31:0] STEP  = 32'd1,
    parameter int          CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_words,
    input  logic [31:0]      i_seed,
    input  logic             i_mode,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [31:0]      o_counter,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_sent_count
);

    state_t           state;
    logic [CNT_W-1:0] num_words_q;
    logic [CNT_W-1:0] sent_next;
    logic             last_xfer;
    logic [31:0]      next_word;
    logic [31:0]      start_word;

    assign sent_next = o_sent_count + CNT_W'(1);
    assign last_xfer = (sent_next == num_words_q);

`ifdef PIPE_STIM_LFSR_EN
    logic        mode_q;
    logic [31:0] lfsr_next;

    pipe_lfsr32 u_lfsr (
        .state_in  (o_counter),
        .state_out (lfsr_next)
    );

    assign next_word  = mode_q ? lfsr_next : (o_counter + STEP);
    assign start_word = i_mode ? lfsr_seed_fix(i_seed) : i_seed;
`else
    logic unused_mode;

    assign unused_mode = i_mode;
    assign next_word   = o_counter + STEP;
    assign start_word  = i_seed;
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, matching the hardware behaviour.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            num_words_q  <= '0;
            o_valid      <= 1'b0;
            o_counter    <= 32'd0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_sent_count <= '0;
`ifdef PIPE_STIM_LFSR_EN
            mode_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_sent_count <= '0;
                        o_counter    <= start_word;
                        num_words_q  <= i_num_words;
`ifdef PIPE_STIM_LFSR_EN
                        mode_q       <= i_mode;
`endif
                        if (i_num_words != '0) begin
                            state   <= ST_RUN;
                            o_valid <= 1'b1;
                            o_busy  <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    // The next word is loaded on the same edge as the transfer, so no bubble.
                    if (o_valid && i_ready) begin
                        o_sent_count <= sent_next;
                        if (last_xfer) begin
                            state   <= ST_DONE;
                            o_valid <= 1'b0;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end else begin
                            o_counter <= next_word;
                        end
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_done <= 1'b0;
                end

                default: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
